// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush/forward control for the 5-stage RV32I pipe.
// Optional perf counters are compiled in when HAZARD_PERF_EN is defined.
module hazard_controller #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic                      LoadE,
  input  logic                      PCSrcE,
  input  logic                      MemReqM,
  input  logic                      mem_ready,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushW,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output logic [CNT_WIDTH-1:0]      flush_count
`endif
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TMO = WW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    INIT,
    RUN,
    MEM_WAIT
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [WW-1:0] wcnt;
  logic [WW-1:0] wcnt_nx;
  logic          err_nx;

  logic m_hit_a;
  logic w_hit_a;
  logic m_hit_b;
  logic w_hit_b;
  logic lw_stall;
  logic timeout;
  logic mem_stall;

  assign m_hit_a = RegWriteM && (RdM != '0) && (RdM == Rs1E);
  assign w_hit_a = RegWriteW && (RdW != '0) && (RdW == Rs1E);
  assign m_hit_b = RegWriteM && (RdM != '0) && (RdM == Rs2E);
  assign w_hit_b = RegWriteW && (RdW != '0) && (RdW == Rs2E);

  assign lw_stall = LoadE && (RdE != '0)
                 && ((RdE == Rs1D) || (RdE == Rs2D));

  assign timeout = (wcnt == TMO);

  // mem_ready and the timeout both release the wait combinationally
  assign mem_stall = (state == MEM_WAIT)
                   ? !(mem_ready || timeout)
                   : ((state == RUN) && MemReqM && !mem_ready);

  // Execute-stage forwarding: M result beats W result
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (m_hit_a)      ForwardAE = 2'b10;
    else if (w_hit_a) ForwardAE = 2'b01;
    if (m_hit_b)      ForwardBE = 2'b10;
    else if (w_hit_b) ForwardBE = 2'b01;
  end

  // State, wait counter and error flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_nx;
      wcnt    <= wcnt_nx;
      mem_err <= err_nx;
    end
  end

  // Next state plus stall/flush controls
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    err_nx   = mem_err;
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    StallM   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushW   = 1'b0;

    unique case (1'b1)
      (state == INIT): begin
        FlushD = 1'b1;
        FlushE = 1'b1;
        FlushW = 1'b1;
      end
      mem_stall: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end
      default: begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushE = lw_stall || PCSrcE;
        FlushD = PCSrcE;
      end
    endcase

    unique case (state)
      INIT: begin
        state_nx = RUN;
        wcnt_nx  = '0;
      end
      RUN: begin
        if (MemReqM && !mem_ready) begin
          state_nx = MEM_WAIT;
          wcnt_nx  = WW'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_nx = RUN;
          wcnt_nx  = '0;
        end else if (timeout) begin
          state_nx = RUN;
          wcnt_nx  = '0;
          err_nx   = 1'b1;
        end else begin
          wcnt_nx = wcnt + WW'(1);
        end
      end
      default: begin
        state_nx = INIT;
        wcnt_nx  = '0;
      end
    endcase
  end

`ifdef HAZARD_PERF_EN
  // Stall-cycle and flush-event counters, wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (StallF)
        stall_cycles <= stall_cycles + CNT_WIDTH'(1);
      if ((state != INIT) && (FlushD || FlushE))
        flush_count <= flush_count + CNT_WIDTH'(1);
    end
  end
`else
  logic [CNT_WIDTH-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: table vectors, hand sequences and random
// stimulus checked against a cycle-level behavioural model.
module tb_hazard_controller;

  localparam int AW = 5;
  localparam int TO = 16;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, mem_ready;
  logic StallF, StallD, StallE, StallM;
  logic FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic mem_err;
  logic [CW-1:0] stall_cycles, flush_count;
  logic [10:0] ctl_act;

  always #5 clk = ~clk;

  hazard_controller #(
    .REG_ADDR_WIDTH(AW),
    .MEM_TIMEOUT(TO),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .mem_ready(mem_ready),
    .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_err(mem_err)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count(flush_count)
`endif
  );

`ifndef HAZARD_PERF_EN
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

  assign ctl_act = {StallF, StallD, StallE, StallM,
                    FlushD, FlushE, FlushW,
                    ForwardAE, ForwardBE};

  int checks = 0;
  int errors = 0;

  // model: 0 = boot scrub, 1 = running, 2 = waiting on memory
  int m_mode;
  int m_elapsed;
  bit m_err;
  logic [CW-1:0] m_stall;
  logic [CW-1:0] m_flush;

  typedef struct {
    string name;
    logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic rwm, rww, lde, pc, mreq, rdy;
    logic [10:0] exp;
  } vec_t;

  vec_t tab[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int fwd(input logic [AW-1:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2;
    if (RegWriteW && RdW != 0 && RdW == rs) return 1;
    return 0;
  endfunction

  function automatic logic [10:0] model_ctl();
    bit lw, busy;
    logic sf, sd, se, sm, fd, fe, fw;
    lw = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    {sf, sd, se, sm, fd, fe, fw} = '0;
    if (m_mode == 0) begin
      {fd, fe, fw} = 3'b111;
    end else begin
      if (m_mode == 2) busy = !(mem_ready || m_elapsed >= TO);
      else busy = MemReqM && !mem_ready;
      if (busy) begin
        {sf, sd, se, sm, fw} = 5'b11111;
      end else begin
        sf = lw;
        sd = lw;
        fe = lw || PCSrcE;
        fd = PCSrcE;
      end
    end
    return {sf, sd, se, sm, fd, fe, fw,
            2'(fwd(Rs1E)), 2'(fwd(Rs2E))};
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_elapsed = 0;
    m_err = 0;
    m_stall = '0;
    m_flush = '0;
  endtask

  task automatic advance();
    logic [10:0] e;
    e = model_ctl();
    @(posedge clk);
    if (e[10]) m_stall = m_stall + 1;
    if (m_mode != 0 && (e[6] || e[5])) m_flush = m_flush + 1;
    case (m_mode)
      0: m_mode = 1;
      1: if (MemReqM && !mem_ready) begin
           m_mode = 2;
           m_elapsed = 1;
         end
      default: begin
        if (mem_ready) m_mode = 1;
        else if (m_elapsed == TO) begin
          m_mode = 1;
          m_err = 1;
        end else m_elapsed++;
      end
    endcase
    #1;
  endtask

  task automatic step(input string name, input bit hand,
                      input logic [10:0] hexp);
    @(negedge clk);
    if (hand) chk(name, ctl_act, hexp);
    chk({name, "_model"}, ctl_act, model_ctl());
    chk({name, "_err"}, mem_err, m_err);
`ifdef HAZARD_PERF_EN
    chk({name, "_stallcnt"}, stall_cycles, m_stall);
    chk({name, "_flushcnt"}, flush_count, m_flush);
`endif
    advance();
  endtask

  task automatic clr_in();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, mem_ready} = '0;
  endtask

  task automatic apply(input vec_t v);
    Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
    RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
    RegWriteM = v.rwm; RegWriteW = v.rww; LoadE = v.lde;
    PCSrcE = v.pc; MemReqM = v.mreq; mem_ready = v.rdy;
  endtask

  function automatic vec_t mkv(
    input string n,
    input int rs1d, input int rs2d, input int rs1e, input int rs2e,
    input int rde, input int rdm, input int rdw,
    input bit rwm, input bit rww, input bit lde, input bit pc,
    input bit mreq, input bit rdy, input logic [10:0] exp);
    vec_t v;
    v.name = n;
    v.rs1d = AW'(rs1d); v.rs2d = AW'(rs2d);
    v.rs1e = AW'(rs1e); v.rs2e = AW'(rs2e);
    v.rde = AW'(rde); v.rdm = AW'(rdm); v.rdw = AW'(rdw);
    v.rwm = rwm; v.rww = rww; v.lde = lde; v.pc = pc;
    v.mreq = mreq; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("init", 1, 11'h070);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_in();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", ctl_act, 11'h070);
    chk("rst_err", mem_err, 0);
`ifdef HAZARD_PERF_EN
    chk("rst_stallcnt", stall_cycles, 0);
    chk("rst_flushcnt", flush_count, 0);
`endif
    release_reset();
    step("idle", 1, 11'h000);
  endtask

  initial begin
    clr_in();
    tab.push_back(mkv("lu_rs1", 5,0,0,0, 5,0,0, 0,0,1,0,0,0, 11'h620));
    tab.push_back(mkv("lu_rd0", 0,0,0,0, 0,0,0, 0,0,1,0,0,0, 11'h000));
    tab.push_back(mkv("fwd_m",  0,0,3,4, 0,3,3, 1,1,0,0,0,0, 11'h008));
    tab.push_back(mkv("fwd_w",  0,0,3,4, 0,3,3, 0,1,0,0,0,0, 11'h004));
    tab.push_back(mkv("fwd_x0", 0,0,0,0, 0,0,0, 1,1,0,0,0,0, 11'h000));
    tab.push_back(mkv("branch", 0,0,0,0, 0,0,0, 0,0,0,1,0,0, 11'h060));
    tab.push_back(mkv("lu_br",  5,0,0,0, 5,0,0, 0,0,1,1,0,0, 11'h660));
    tab.push_back(mkv("lu_rs2", 0,7,0,0, 7,0,0, 0,0,1,0,0,0, 11'h620));
    tab.push_back(mkv("noload", 7,0,0,0, 7,0,0, 0,0,0,0,0,0, 11'h000));
    tab.push_back(mkv("fwd_mix",0,0,8,9, 0,8,9, 1,1,0,0,0,0, 11'h009));
    tab.push_back(mkv("mem_ok", 0,0,0,0, 0,0,0, 0,0,0,0,1,1, 11'h000));

    do_reset();

    foreach (tab[i]) begin
      apply(tab[i]);
      step(tab[i].name, 1, tab[i].exp);
    end
    clr_in();

    // three wait cycles then completion
    MemReqM = 1'b1;
    for (int i = 0; i < 3; i++) step("memwait", 1, 11'h790);
    mem_ready = 1'b1;
    step("mem_release", 1, 11'h000);
    clr_in();
    chk("memwait_noerr", mem_err, 0);

    // completion arrives in the timeout cycle
    MemReqM = 1'b1;
    for (int i = 0; i < TO; i++) step("tie_wait", 1, 11'h790);
    mem_ready = 1'b1;
    step("tie_release", 1, 11'h000);
    clr_in();
    step("tie_idle", 1, 11'h000);
    chk("tie_noerr", mem_err, 0);

    // full timeout
    MemReqM = 1'b1;
    for (int i = 0; i < TO; i++) step("to_wait", 1, 11'h790);
    step("to_release", 1, 11'h000);
    clr_in();
    chk("to_err", mem_err, 1);
    for (int i = 0; i < 3; i++) step("to_idle", 1, 11'h000);
    chk("to_sticky", mem_err, 1);

    // asynchronous reset in the middle of a wait
    MemReqM = 1'b1;
    for (int i = 0; i < 3; i++) step("pre_arst", 1, 11'h790);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctl", ctl_act, 11'h070);
    chk("arst_err", mem_err, 0);
    model_reset();
    clr_in();
    release_reset();

    // branch resolved while memory is stalled
    MemReqM = 1'b1;
    PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) step("br_wait", 1, 11'h790);
    mem_ready = 1'b1;
    step("br_release", 1, 11'h060);
    clr_in();
`ifdef HAZARD_PERF_EN
    chk("br_flushcnt", flush_count, 1);
    chk("br_stallcnt", stall_cycles, 3);
`endif

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      Rs1D = AW'($urandom_range(0, 3));
      Rs2D = AW'($urandom_range(0, 3));
      Rs1E = AW'($urandom_range(0, 3));
      Rs2E = AW'($urandom_range(0, 3));
      RdE  = AW'($urandom_range(0, 3));
      RdM  = AW'($urandom_range(0, 3));
      RdW  = AW'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      LoadE     = 1'($urandom_range(0, 1));
      PCSrcE    = ($urandom_range(0, 3) == 0);
      MemReqM   = ($urandom_range(0, 3) == 0);
      mem_ready = ($urandom_range(0, 4) == 0);
      step("rnd", 0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
